// File: rtl/bat_amateur_pkg.sv
// Shared types and constants for the BatAmateur program loader.
package bat_amateur_pkg;

    localparam int unsigned DEF_ADDRESS_WIDTH = 16;
    localparam int unsigned DEF_DATA_WIDTH    = 16;

    localparam logic RAM_RW_WRITE = 1'b0;
    localparam logic RAM_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        S_GRAB,
        S_ADDR,
        S_COUNT,
        S_DATA,
        S_SETTLE_UP,
        S_RUN
    } state_e;

endpackage

// File: rtl/bat_amateur_settle_timer.sv
// Saturating 4-bit down-counter; done once SETTLE_CYCLES-1 cycles have elapsed since load/reset.
module bat_amateur_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic done
);

    localparam logic [3:0] LOAD_VALUE = 4'(SETTLE_CYCLES - 1);

    logic [3:0] count_q;

    // Reset counts as a load so the post-reset grab interval matches a reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LOAD_VALUE;
        end else if (load) begin
            count_q <= LOAD_VALUE;
        end else if (count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done = (count_q == 4'd0);

endmodule

// File: rtl/bat_amateur_loader.sv
// Boot loader and RAM bus owner: streams header+payload into RAM while the CPU is halted.
module bat_amateur_loader
    import bat_amateur_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic                     LOAD_REQ,
    output logic                     HALT,
    output logic                     RAM_EN,
    output logic                     RAM_RW,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS_OUT,
    output logic [DATA_WIDTH-1:0]    DATA_OUT,
    output logic                     BUS_OE,
    output logic                     LOAD_DONE
);

    localparam logic [DATA_WIDTH-1:0]    CNT_ONE  = DATA_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
    logic                     halt_q, halt_d;
    logic                     bus_oe_q, bus_oe_d;
    logic                     ram_en_q, ram_en_d;
    logic                     ram_rw_q, ram_rw_d;
    logic [ADDRESS_WIDTH-1:0] addr_out_q, addr_out_d;
    logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
    logic                     in_ready_q, in_ready_d;
    logic                     load_done_q, load_done_d;

    logic xfer;
    logic timer_load;
    logic timer_done;

    assign xfer = IN_VALID && in_ready_q;

    // Settle interval restarts on the HALT rise (reload) and on the bus release cycle.
    assign timer_load = ((state_q == S_RUN) && LOAD_REQ) ||
                        ((state_q == S_SETTLE_UP) && load_done_q);

    bat_amateur_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk  (CLK),
        .rst_n(RESET),
        .load (timer_load),
        .done (timer_done)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        bus_oe_d   = bus_oe_q;
        ram_en_d   = 1'b0;
        ram_rw_d   = RAM_RW_READ;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;

        unique case (state_q)
            S_GRAB: begin
                if (timer_done) begin
                    bus_oe_d = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (xfer) begin
                    addr_d  = IN_DATA[ADDRESS_WIDTH-1:0];
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    cnt_d   = IN_DATA;
                    state_d = (IN_DATA == '0) ? S_SETTLE_UP : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    ram_en_d   = 1'b1;
                    ram_rw_d   = RAM_RW_WRITE;
                    addr_out_d = addr_q;
                    data_out_d = IN_DATA;
                    addr_d     = addr_q + ADDR_ONE;
                    cnt_d      = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_SETTLE_UP;
                    end
                end
            end
            S_SETTLE_UP: begin
                // First cycle carries the final write; release the bus right after it.
                if (load_done_q) begin
                    bus_oe_d = 1'b0;
                end else if (timer_done) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (LOAD_REQ) begin
                    state_d = S_GRAB;
                end
            end
            default: state_d = S_GRAB;
        endcase

        in_ready_d  = (state_d == S_ADDR) || (state_d == S_COUNT) || (state_d == S_DATA);
        load_done_d = (state_d == S_SETTLE_UP) && (state_q != S_SETTLE_UP);
        halt_d      = (state_d != S_RUN);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_GRAB;
            addr_q      <= '0;
            cnt_q       <= '0;
            halt_q      <= 1'b1;
            bus_oe_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_rw_q    <= RAM_RW_READ;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            in_ready_q  <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            halt_q      <= halt_d;
            bus_oe_q    <= bus_oe_d;
            ram_en_q    <= ram_en_d;
            ram_rw_q    <= ram_rw_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            in_ready_q  <= in_ready_d;
            load_done_q <= load_done_d;
        end
    end

    assign HALT        = halt_q;
    assign BUS_OE      = bus_oe_q;
    assign RAM_EN      = ram_en_q;
    assign RAM_RW      = ram_rw_q;
    assign ADDRESS_OUT = addr_out_q;
    assign DATA_OUT    = data_out_q;
    assign IN_READY    = in_ready_q;
    assign LOAD_DONE   = load_done_q;

endmodule
